// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters. Round-robin grant, rejects illegal control codes.
// Latency: the response is valid two cycles after the accept cycle (accept, EXEC, then RESP).
// Backpressure: a pending response holds the FSM in RESP, so neither requester is granted until rsp_ready.
module alu_arbiter #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_control,
  input  logic [Width-1:0] req0_operand1,
  input  logic [Width-1:0] req0_operand2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_control,
  input  logic [Width-1:0] req1_operand1,
  input  logic [Width-1:0] req1_operand2,
  output logic [3:0]       alu_control,
  output logic [Width-1:0] alu_operand1,
  output logic [Width-1:0] alu_operand2,
  input  logic [Width-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [Width-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [Width-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_pri;
  logic             r_owner;
  logic             r_err;
  logic [3:0]       r_ctrl;
  logic [Width-1:0] r_op1;
  logic [Width-1:0] r_op2;

  logic             r_rsp0_vld;
  logic [Width-1:0] r_rsp0_result;
  logic             r_rsp0_zero;
  logic             r_rsp0_err;
  logic             r_rsp1_vld;
  logic [Width-1:0] r_rsp1_result;
  logic             r_rsp1_zero;
  logic             r_rsp1_err;

  logic             w_gnt_vld;
  logic             w_gnt_id;
  logic             w_accept;
  logic             w_rsp_hs;
  logic             w_drive_alu;
  logic [3:0]       w_sel_ctrl;
  logic [Width-1:0] w_sel_op1;
  logic [Width-1:0] w_sel_op2;

  // Only these codes are understood by the shared ALU; anything else becomes an error response.
  function automatic logic f_legal(input logic [3:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011,
      4'b0100, 4'b0101, 4'b0111, 4'b1000: f_legal = 1'b1;
      default:                            f_legal = 1'b0;
    endcase
  endfunction

  // Grant selection: round-robin pointer breaks ties, a lone requester always wins.
  always_comb begin
    w_gnt_vld = req0_valid | req1_valid;
    w_gnt_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt_id = r_pri;
    end else if (req1_valid) begin
      w_gnt_id = 1'b1;
    end
  end

  assign req0_ready = (r_state == IDLE) && w_gnt_vld && !w_gnt_id;
  assign req1_ready = (r_state == IDLE) && w_gnt_vld &&  w_gnt_id;
  assign w_accept   = (r_state == IDLE) && w_gnt_vld;

  assign w_sel_ctrl = w_gnt_id ? req1_control  : req0_control;
  assign w_sel_op1  = w_gnt_id ? req1_operand1 : req0_operand1;
  assign w_sel_op2  = w_gnt_id ? req1_operand2 : req0_operand2;

  // A response handshake only counts on the channel that owns the current operation.
  assign w_rsp_hs = (r_state == RESP) &&
                    (r_owner ? (r_rsp1_vld && rsp1_ready) : (r_rsp0_vld && rsp0_ready));

  // Illegal codes never reach the ALU: it sees zeros unless a legal op is executing.
  assign w_drive_alu  = (r_state == EXEC) && !r_err;
  assign alu_control  = w_drive_alu ? r_ctrl : 4'b0000;
  assign alu_operand1 = w_drive_alu ? r_op1  : '0;
  assign alu_operand2 = w_drive_alu ? r_op2  : '0;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: EXEC always lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the granted operation, its owner and its legality on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= 4'b0000;
      r_op1   <= '0;
      r_op2   <= '0;
      r_owner <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_ctrl  <= w_sel_ctrl;
      r_op1   <= w_sel_op1;
      r_op2   <= w_sel_op2;
      r_owner <= w_gnt_id;
      r_err   <= !f_legal(w_sel_ctrl);
    end
  end

  // Priority moves to the other requester only when a response is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pri <= 1'b0;
    end else if (w_rsp_hs) begin
      r_pri <= ~r_owner;
    end
  end

  // Response channel 0: capture at the end of EXEC, hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_vld    <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp0_zero   <= 1'b0;
      r_rsp0_err    <= 1'b0;
    end else if ((r_state == EXEC) && !r_owner) begin
      r_rsp0_vld    <= 1'b1;
      r_rsp0_result <= r_err ? '0 : alu_result;
      r_rsp0_zero   <= r_err ? 1'b0 : alu_zero;
      r_rsp0_err    <= r_err;
    end else if (w_rsp_hs && !r_owner) begin
      r_rsp0_vld    <= 1'b0;
    end
  end

  // Response channel 1: same as channel 0 for the other owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp1_vld    <= 1'b0;
      r_rsp1_result <= '0;
      r_rsp1_zero   <= 1'b0;
      r_rsp1_err    <= 1'b0;
    end else if ((r_state == EXEC) && r_owner) begin
      r_rsp1_vld    <= 1'b1;
      r_rsp1_result <= r_err ? '0 : alu_result;
      r_rsp1_zero   <= r_err ? 1'b0 : alu_zero;
      r_rsp1_err    <= r_err;
    end else if (w_rsp_hs && r_owner) begin
      r_rsp1_vld    <= 1'b0;
    end
  end

  assign rsp0_valid  = r_rsp0_vld;
  assign rsp0_result = r_rsp0_result;
  assign rsp0_zero   = r_rsp0_zero;
  assign rsp0_err    = r_rsp0_err;
  assign rsp1_valid  = r_rsp1_vld;
  assign rsp1_result = r_rsp1_result;
  assign rsp1_zero   = r_rsp1_zero;
  assign rsp1_err    = r_rsp1_err;

endmodule
